stage_decode: RTL and testbench
===============================

# stage_decode

Decode stage of the five-stage pipelined MIPS core, between the fetch stage and the execute datapath. Holds the IF/ID pipeline register, the 32×32 register file with write-through bypass, and sign extension. It registers operands and register specifiers into the ID/EX pipeline register. Stall and flush inputs come from the hazard unit. The WB-stage write port comes from the writeback stage.

## Interface
- `WIDTH`, 32, data/instruction width
- `NREGS`, 32, register count; specifier width is 5 bits
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `instr_F`  in  32  instruction from fetch
- `pcplus4_F`  in  32  PC+4 from fetch
- `stall_D`  in  1  hold IF/ID contents
- `flush_D`  in  1  load NOP into IF/ID
- `flush_E`  in  1  load bubble into ID/EX
- `REGWRITE_WB`  in  1  register-file write enable
- `writereg_WB`  in  5  write address
- `result_WB`  in  32  write data
- `instr_D`  out  32  IF/ID instruction; feeds the controller opcode/funct
- `pcplus4_E`  out  32  PC+4 for the EX branch adder
- `rd1_E`, `rd2_E`  out  32  operands for rs/rt
- `signimm_E`  out  32  sign-extended immediate
- `rs_E`, `rt_E`, `rd_E`  out  5  specifiers for forwarding and regdst
- `valid_E`  out  1  ID/EX holds a real instruction (0 = bubble)

## Operation
- **IF/ID update priority:** `reset` > `flush_D` > `stall_D` > load.
  - `reset` or `flush_D`: `instr_D` = 0x00000000 (NOP, sll $0), internal `pcplus4_D` = 0, `valid_D` = 0.
  - `stall_D`: all IF/ID fields hold.
  - Otherwise: capture `instr_F` and `pcplus4_F`, and set `valid_D` = 1.
- **Register file:**
  - Two combinational read ports addressed by `instr_D[25:21]` and `instr_D[20:16]`.
  - One synchronous write port.
  - `$0` reads 0 always; writes to it are ignored.
  - Write occurs when `REGWRITE_WB` = 1 and `writereg_WB` ≠ 0.
- **Bypass:** if a read address equals `writereg_WB`, with `REGWRITE_WB` = 1 and the address ≠ 0, the read returns `result_WB` in the same cycle. This replaces the half-cycle write.
- **Sign extension:** `signimm` = {16{`instr_D[15]`}, `instr_D[15:0]`}.
- **ID/EX update priority:** `reset` > `flush_E` > load.
  - `reset` or `flush_E`: all ID/EX outputs = 0, `valid_E` = 0.
  - Otherwise: capture the bypassed reads, `signimm`, `instr_D[25:21]`/`[20:16]`/`[15:11]`, `pcplus4_D`, and `valid_D`.
- `stall_D` does not hold ID/EX. For a load-use hazard the hazard unit asserts `stall_D` and `flush_E` together, so a bubble enters EX while decode holds.
- **Reset:** clears IF/ID, ID/EX, and all register-file entries to 0. Reset mid-stall discards the held instruction.
- **Simultaneous `flush_D` and `stall_D`:** flush wins.
- **Simultaneous write and stalled read of the same register:** the bypass covers the current cycle; the array supplies the value on later cycles.

## Timing
- `instr_F` at edge N appears on `instr_D` after edge N. The corresponding E outputs appear after edge N+1, a latency of 2 cycles.
- A WB write at edge N is visible in `rd1_E`/`rd2_E` captured at that same edge N, through the bypass.
- The read path is combinational through bypass muxes into the ID/EX flops; there is no comb path from any input to any output.
- All outputs are 0 in the cycle after `reset` is sampled high.

## Structure
- Shared package `mips_pkg`:
  - `NOP` constant (32'h0).
  - Field-position localparams: RS [25:21], RT [20:16], RD [15:11], IMM [15:0].
  - `reg_addr_t` (5-bit) typedef.
  - `id_ex_t` packed struct for the ID/EX register.
- Sub-module `regfile`: array, reset clear, write port, two bypassed read ports. The decode stage instantiates it once.

## Test plan
- **Reset, then flush:** reset held 2 cycles → every output 0, `valid_E` = 0. Apply `flush_D` → `instr_D` = 0x00000000.
- **Writeback then read:** write `$8` = 0x12345678 at cycle N. Instr 0x01095020 (add `$10`,`$8`,`$9`) → `rd1_E` = 0x12345678, `rs_E` = 8, `rt_E` = 9, `rd_E` = 10.
- **Same-cycle bypass:** `REGWRITE_WB` = 1, `writereg_WB` = 8, `result_WB` = 0xDEADBEEF in the cycle `instr_D` reads `$8` → `rd1_E` = 0xDEADBEEF.
- **`$0` protection:** write 0xFFFFFFFF to `$0`, then read `$0` → `rd1_E` = 0.
- **Sign extension:** 0x2008FFFC (addi `$8`,`$0`,-4) → `signimm_E` = 0xFFFFFFFC. Then 0x20087FFF → `signimm_E` = 0x00007FFF.
- **Load-use:** `stall_D` = 1 and `flush_E` = 1 for one cycle → `instr_D` unchanged, `valid_E` = 0. The next cycle re-issues the same instruction with `valid_E` = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, the NOP encoding
// and the ID/EX pipeline register layout.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        pcplus4;
        logic [XLEN-1:0]        rd1;
        logic [XLEN-1:0]        rd2;
        logic signed [XLEN-1:0] signimm;
        reg_addr_t              rs;
        reg_addr_t              rt;
        reg_addr_t              rd;
    } id_ex_t;

endpackage

// File: rtl/regfile.sv
// 32-entry register file: one synchronous write port, two combinational read
// ports that bypass the write data when reading the register being written.
module regfile
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  reg_addr_t        wa,
    input  logic [WIDTH-1:0] wd,
    input  reg_addr_t        ra1,
    input  reg_addr_t        ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // $0 is hard-wired; the bypass stands in for a write-first-half/read-second-half file
    assign rd1 = (ra1 == '0)             ? '0 :
                 (we && (wa == ra1))     ? wd : mem[ra1];
    assign rd2 = (ra2 == '0)             ? '0 :
                 (we && (wa == ra2))     ? wd : mem[ra2];

endmodule

// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, register file with WB bypass, sign extension
// and the ID/EX register feeding the execute datapath.
module stage_decode
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_F,
    input  logic [WIDTH-1:0] pcplus4_F,
    input  logic             stall_D,
    input  logic             flush_D,
    input  logic             flush_E,
    input  logic             REGWRITE_WB,
    input  reg_addr_t        writereg_WB,
    input  logic [WIDTH-1:0] result_WB,
    output logic [WIDTH-1:0] instr_D,
    output logic [WIDTH-1:0] pcplus4_E,
    output logic [WIDTH-1:0] rd1_E,
    output logic [WIDTH-1:0] rd2_E,
    output logic [WIDTH-1:0] signimm_E,
    output reg_addr_t        rs_E,
    output reg_addr_t        rt_E,
    output reg_addr_t        rd_E,
    output logic             valid_E
);

    function automatic logic signed [WIDTH-1:0] sign_extend(input logic [15:0] imm);
        return {{(WIDTH-16){imm[15]}}, imm};
    endfunction

    logic [WIDTH-1:0] pcplus4_D;
    logic             valid_D;
    logic [WIDTH-1:0] rd1_D;
    logic [WIDTH-1:0] rd2_D;
    id_ex_t           id_ex_d;
    id_ex_t           id_ex_q;

    // IF/ID boundary
    always_ff @(posedge clk) begin
        if (reset || flush_D) begin
            instr_D   <= NOP;
            pcplus4_D <= '0;
            valid_D   <= 1'b0;
        end else if (!stall_D) begin
            instr_D   <= instr_F;
            pcplus4_D <= pcplus4_F;
            valid_D   <= 1'b1;
        end
    end

    regfile #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (REGWRITE_WB),
        .wa    (writereg_WB),
        .wd    (result_WB),
        .ra1   (instr_D[RS_HI:RS_LO]),
        .ra2   (instr_D[RT_HI:RT_LO]),
        .rd1   (rd1_D),
        .rd2   (rd2_D)
    );

    always_comb begin
        id_ex_d         = '0;
        id_ex_d.valid   = valid_D;
        id_ex_d.pcplus4 = pcplus4_D;
        id_ex_d.rd1     = rd1_D;
        id_ex_d.rd2     = rd2_D;
        id_ex_d.signimm = sign_extend(instr_D[IMM_HI:IMM_LO]);
        id_ex_d.rs      = instr_D[RS_HI:RS_LO];
        id_ex_d.rt      = instr_D[RT_HI:RT_LO];
        id_ex_d.rd      = instr_D[RD_HI:RD_LO];
    end

    // ID/EX boundary: stall_D deliberately does not hold this register
    always_ff @(posedge clk) begin
        if (reset || flush_E) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign pcplus4_E = id_ex_q.pcplus4;
    assign rd1_E     = id_ex_q.rd1;
    assign rd2_E     = id_ex_q.rd2;
    assign signimm_E = id_ex_q.signimm;
    assign rs_E      = id_ex_q.rs;
    assign rt_E      = id_ex_q.rt;
    assign rd_E      = id_ex_q.rd;
    assign valid_E   = id_ex_q.valid;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed vector table followed by randomized
// traffic checked against a cycle-level behavioural model.
module tb_stage_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_F, pcplus4_F;
    logic        stall_D, flush_D, flush_E;
    logic        REGWRITE_WB;
    logic [4:0]  writereg_WB;
    logic [31:0] result_WB;
    logic [31:0] instr_D, pcplus4_E, rd1_E, rd2_E, signimm_E;
    logic [4:0]  rs_E, rt_E, rd_E;
    logic        valid_E;

    int n_checks = 0;
    int n_fail   = 0;

    stage_decode #(.WIDTH(32), .NREGS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_F     (instr_F),
        .pcplus4_F   (pcplus4_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .REGWRITE_WB (REGWRITE_WB),
        .writereg_WB (writereg_WB),
        .result_WB   (result_WB),
        .instr_D     (instr_D),
        .pcplus4_E   (pcplus4_E),
        .rd1_E       (rd1_E),
        .rd2_E       (rd2_E),
        .signimm_E   (signimm_E),
        .rs_E        (rs_E),
        .rt_E        (rt_E),
        .rd_E        (rd_E),
        .valid_E     (valid_E)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register values plus the two pipeline slots
    logic [31:0] m_rf [32];
    logic [31:0] m_instr_d, m_pc_d;
    logic        m_valid_d;
    logic [31:0] m_pc_e, m_rd1_e, m_rd2_e, m_imm_e;
    logic [4:0]  m_rs_e, m_rt_e, m_rd_e;
    logic        m_valid_e;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (REGWRITE_WB && writereg_WB == a) return result_WB;
        return m_rf[a];
    endfunction

    task automatic model_edge();
        logic [31:0] ins;
        ins = m_instr_d;
        if (reset || flush_E) begin
            {m_pc_e, m_rd1_e, m_rd2_e, m_imm_e} = '0;
            {m_rs_e, m_rt_e, m_rd_e, m_valid_e} = '0;
        end else begin
            m_rd1_e   = m_read(ins[25:21]);
            m_rd2_e   = m_read(ins[20:16]);
            m_imm_e   = 32'($signed(ins[15:0]));
            m_rs_e    = ins[25:21];
            m_rt_e    = ins[20:16];
            m_rd_e    = ins[15:11];
            m_pc_e    = m_pc_d;
            m_valid_e = m_valid_d;
        end
        if (reset || flush_D) begin
            m_instr_d = 32'd0; m_pc_d = 32'd0; m_valid_d = 1'b0;
        end else if (!stall_D) begin
            m_instr_d = instr_F; m_pc_d = pcplus4_F; m_valid_d = 1'b1;
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (REGWRITE_WB && writereg_WB != 5'd0) begin
            m_rf[writereg_WB] = result_WB;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit fd, input bit fe,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] ins, input logic [31:0] pc);
        reset = rst; stall_D = st; flush_D = fd; flush_E = fe;
        REGWRITE_WB = we; writereg_WB = wa; result_WB = wd;
        instr_F = ins; pcplus4_F = pc;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst, stall, fd, fe, we;
        logic [4:0]  wa;
        logic [31:0] wd, instr, pc;
        logic [31:0] e_instr_d, e_pc, e_rd1, e_rd2, e_imm;
        logic [4:0]  e_rs, e_rt, e_rd;
        bit          e_valid;
    } vec_t;

    vec_t vecs [15];

    initial begin
        reset = 1'b1; stall_D = 0; flush_D = 0; flush_E = 0;
        REGWRITE_WB = 0; writereg_WB = 0; result_WB = 0; instr_F = 0; pcplus4_F = 0;

        // rst stall fd fe we wa wd instr pc | instr_D pc_E rd1 rd2 imm rs rt rd valid
        vecs[0]  = '{1,0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0,0};
        vecs[1]  = '{1,0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0,0};
        vecs[2]  = '{0,0,1,0,0,0,0,32'h01095020,4,                   0,0,0,0,0,0,0,0,0};
        vecs[3]  = '{0,0,0,0,1,8,32'h12345678,32'h01095020,8,        32'h01095020,0,0,0,0,0,0,0,0};
        vecs[4]  = '{0,0,0,0,0,0,0,0,12,                             0,8,32'h12345678,0,32'h5020,8,9,10,1};
        vecs[5]  = '{0,0,0,0,0,0,0,32'h01095020,16,                  32'h01095020,12,0,0,0,0,0,0,1};
        vecs[6]  = '{0,0,0,0,1,8,32'hDEADBEEF,0,20,                  0,16,32'hDEADBEEF,0,32'h5020,8,9,10,1};
        vecs[7]  = '{0,0,0,0,1,0,32'hFFFFFFFF,32'h2008FFFC,24,       32'h2008FFFC,20,0,0,0,0,0,0,1};
        vecs[8]  = '{0,0,0,0,0,0,0,32'h20087FFF,28,                  32'h20087FFF,24,0,32'hDEADBEEF,32'hFFFFFFFC,0,8,31,1};
        vecs[9]  = '{0,0,0,0,0,0,0,32'h01095020,32,                  32'h01095020,28,0,32'hDEADBEEF,32'h00007FFF,0,8,15,1};
        vecs[10] = '{0,1,0,1,0,0,0,32'hAAAAAAAA,36,                  32'h01095020,0,0,0,0,0,0,0,0};
        vecs[11] = '{0,0,0,0,0,0,0,0,40,                             0,32,32'hDEADBEEF,0,32'h5020,8,9,10,1};
        vecs[12] = '{0,0,0,0,0,0,0,32'h01095020,44,                  32'h01095020,40,0,0,0,0,0,0,1};
        vecs[13] = '{1,1,0,0,0,0,0,32'h01095020,48,                  0,0,0,0,0,0,0,0,0};
        vecs[14] = '{0,1,1,0,0,0,0,32'h12345678,52,                  0,0,0,0,0,0,0,0,0};

        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].fd, vecs[i].fe, vecs[i].we,
                 vecs[i].wa, vecs[i].wd, vecs[i].instr, vecs[i].pc);
            chk($sformatf("vec%0d instr_D", i),   instr_D,   vecs[i].e_instr_d);
            chk($sformatf("vec%0d pcplus4_E", i), pcplus4_E, vecs[i].e_pc);
            chk($sformatf("vec%0d rd1_E", i),     rd1_E,     vecs[i].e_rd1);
            chk($sformatf("vec%0d rd2_E", i),     rd2_E,     vecs[i].e_rd2);
            chk($sformatf("vec%0d signimm_E", i), signimm_E, vecs[i].e_imm);
            chk($sformatf("vec%0d rs_E", i),      32'(rs_E), 32'(vecs[i].e_rs));
            chk($sformatf("vec%0d rt_E", i),      32'(rt_E), 32'(vecs[i].e_rt));
            chk($sformatf("vec%0d rd_E", i),      32'(rd_E), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d valid_E", i),   32'(valid_E), 32'(vecs[i].e_valid));
        end

        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                ins[25:21] = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 ins, $urandom);
            chk($sformatf("rnd%0d instr_D", c),   instr_D,   m_instr_d);
            chk($sformatf("rnd%0d pcplus4_E", c), pcplus4_E, m_pc_e);
            chk($sformatf("rnd%0d rd1_E", c),     rd1_E,     m_rd1_e);
            chk($sformatf("rnd%0d rd2_E", c),     rd2_E,     m_rd2_e);
            chk($sformatf("rnd%0d signimm_E", c), signimm_E, m_imm_e);
            chk($sformatf("rnd%0d rs_E", c),      32'(rs_E), 32'(m_rs_e));
            chk($sformatf("rnd%0d rt_E", c),      32'(rt_E), 32'(m_rt_e));
            chk($sformatf("rnd%0d rd_E", c),      32'(rd_E), 32'(m_rd_e));
            chk($sformatf("rnd%0d valid_E", c),   32'(valid_E), 32'(m_valid_e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
